ysyx_23060278_lsu: RTL and testbench

YSYX_23060278_LSU -- requirements
Module: ysyx_23060278_lsu

---
 rtl/ysyx_23060278_lsu_pkg.sv | 14 +
 rtl/ysyx_23060278_lsu_align.sv | 23 ++
 rtl/ysyx_23060278_lsu.sv | 75 +++++++
 tb/tb_ysyx_23060278_lsu.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060278_lsu_pkg.sv
// ysyx_23060278_lsu_pkg: FSM states, funct3 codes and the request error check.
package ysyx_23060278_lsu_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
    function automatic logic op_err(input logic store, input logic [2:0] f3, input logic [1:0] off);
        logic legal;
        logic mis;
        legal = store ? (f3 == SB || f3 == SH || f3 == SW)
                      : (f3 == LB || f3 == LH || f3 == LW || f3 == LBU || f3 == LHU);
        mis = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
        return !legal || mis;
    endfunction
endpackage

// File: rtl/ysyx_23060278_lsu_align.sv
// ysyx_23060278_lsu_align: byte-lane strobes/replication for stores, shift and extend for loads.
module ysyx_23060278_lsu_align
    import ysyx_23060278_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);
    logic [31:0] sh;
    always_comb begin
        wstrb = funct3[1:0] == 2'b00 ? 4'b0001 << off : funct3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
        wdata_lane = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} : funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
        sh = rdata >> {off, 3'b000};
        rdata_ext = funct3 == LB  ? {{24{sh[7]}}, sh[7:0]} :
                    funct3 == LH  ? {{16{sh[15]}}, sh[15:0]} :
                    funct3 == LBU ? {24'b0, sh[7:0]} :
                    funct3 == LHU ? {16'b0, sh[15:0]} : sh;
    end
endmodule

// File: rtl/ysyx_23060278_lsu.sv
// ysyx_23060278_lsu: single-outstanding load/store unit bridging execute to a 32-bit word memory port.
module ysyx_23060278_lsu
    import ysyx_23060278_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    state_t state;
    logic store_q;
    logic [2:0] funct3_q;
    logic [31:0] addr_q, wdata_q, lane, ext;
    logic [3:0] strb;
    logic bad;
    ysyx_23060278_lsu_align u_align (
        .funct3(funct3_q), .off(addr_q[1:0]), .wdata(wdata_q), .rdata(mem_rdata),
        .wstrb(strb), .wdata_lane(lane), .rdata_ext(ext)
    );
    assign bad = op_err(req_store, req_funct3, req_addr[1:0]);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            store_q <= 1'b0;
            funct3_q <= 3'b0;
            addr_q <= 32'b0;
            wdata_q <= 32'b0;
            resp_rdata <= 32'b0;
            resp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    store_q <= req_store;
                    funct3_q <= req_funct3;
                    addr_q <= req_addr;
                    wdata_q <= req_wdata;
                    resp_rdata <= 32'b0;
                    resp_err <= bad;
                    state <= bad ? RESP : REQ;
                end
                REQ: if (mem_req_ready) state <= WAIT;
                WAIT: if (mem_rsp_valid) begin
                    resp_rdata <= store_q ? 32'b0 : ext;
                    state <= RESP;
                end
                RESP: state <= IDLE;
            endcase
        end
    end
    // Write-side outputs are forced to zero whenever no write request is on the port.
    always_comb begin
        req_ready = state == IDLE;
        mem_req_valid = state == REQ;
        mem_addr = {addr_q[31:2], 2'b00};
        mem_wen = mem_req_valid && store_q;
        mem_wstrb = mem_wen ? strb : 4'b0;
        mem_wdata = mem_wen ? lane : 32'b0;
        resp_valid = state == RESP;
    end
endmodule

// File: tb/tb_ysyx_23060278_lsu.sv
// tb_ysyx_23060278_lsu: directed and randomized checks of the LSU against a byte-level reference model.
module tb_ysyx_23060278_lsu;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_ready, req_store = 1'b0;
    logic [2:0] req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
    logic mem_req_valid, mem_req_ready = 1'b0, mem_wen, mem_rsp_valid = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'b0, resp_rdata;
    logic [3:0] mem_wstrb;
    logic resp_valid, resp_err;
    int errors = 0, checks = 0;

    typedef struct {
        bit saw_req, unstable, idle_dirty, ready_bad, got_resp, post_ok;
        int lat;
        logic [31:0] addr, wdata, rdata;
        logic [3:0] wstrb;
        logic wen, err;
    } obs_t;

    ysyx_23060278_lsu dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // Reference model: access size in bytes, 0 for an unknown funct3.
    function automatic int op_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit exp_err(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int sz = op_size(f3);
        if (sz == 0 || (st && f3 > 3'd2)) return 1'b1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
        int sz = op_size(f3);
        int off = int'(a % 4);
        logic [3:0] s = 4'b0;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + sz) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz = op_size(f3);
        logic [31:0] r = 32'b0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int sz = op_size(f3);
        longint v = longint'((64'(rd) >> (8 * (a % 4))) % (64'd1 << (8 * sz)));
        if (f3 < 3'd4 && sz < 4 && v >= longint'(64'd1 << (8 * sz - 1))) v -= longint'(64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    // Drives one op and a memory with the given ready/response delays; records what the DUT did.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int rdly, input int sdly, input bit stray, output obs_t o);
        int c, w, s;
        bit hs;
        o = '{default: 0};
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_store = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        c = 1; w = 0; s = -1;
        while (c < 40) begin
            mem_rsp_valid = 1'b0; mem_req_ready = 1'b0; mem_rdata = $urandom; hs = 1'b0;
            if (req_ready) o.ready_bad = 1'b1;
            if (resp_valid) begin
                o.got_resp = 1'b1; o.lat = c; o.rdata = resp_rdata; o.err = resp_err;
                break;
            end
            if (s >= 0) begin
                if (s == sdly) begin mem_rsp_valid = 1'b1; mem_rdata = rd; end
                s++;
            end
            if (mem_req_valid) begin
                if (!o.saw_req) begin
                    o.saw_req = 1'b1; o.addr = mem_addr; o.wen = mem_wen; o.wstrb = mem_wstrb; o.wdata = mem_wdata;
                end else if (mem_addr !== o.addr || mem_wen !== o.wen || mem_wstrb !== o.wstrb || mem_wdata !== o.wdata)
                    o.unstable = 1'b1;
                mem_req_ready = 1'(w >= rdly);
                hs = mem_req_ready;
                w++;
                if (stray && $urandom_range(1) == 1) begin mem_rsp_valid = 1'b1; mem_rdata = ~rd; end
            end else if (mem_wen !== 1'b0 || mem_wstrb !== 4'b0 || mem_wdata !== 32'b0) o.idle_dirty = 1'b1;
            if (hs) s = 0;
            @(negedge clk);
            c++;
        end
        mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
        @(negedge clk);
        o.post_ok = resp_valid === 1'b0 && req_ready === 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b1; req_funct3 = 3'd2; req_addr = 32'h1234_5678; mem_rsp_valid = 1'b1; mem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if ({mem_req_valid, mem_wen, mem_wstrb, resp_valid, resp_err} !== 8'b0)
            begin errors++; $display("FAIL reset_ctrl got=%b exp=0", {mem_req_valid, mem_wen, mem_wstrb, resp_valid, resp_err}); end
        checks++; if (resp_rdata !== 32'b0 || mem_wdata !== 32'b0 || mem_addr !== 32'b0)
            begin errors++; $display("FAIL reset_data got=%h/%h/%h exp=0", resp_rdata, mem_wdata, mem_addr); end
        req_valid = 1'b0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lw;
        obs_t o;
        run_op(1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0, o);
        checks++; if (o.addr !== 32'h8000_0004) begin errors++; $display("FAIL lw_addr got=%h exp=80000004", o.addr); end
        checks++; if (o.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata got=%h exp=deadbeef", o.rdata); end
        checks++; if (o.err !== 1'b0 || o.wen !== 1'b0) begin errors++; $display("FAIL lw_err_wen got=%b%b exp=00", o.err, o.wen); end
        checks++; if (!o.got_resp || o.lat != 3) begin errors++; $display("FAIL lw_latency got=%0d exp=3", o.lat); end
        checks++; if (!o.post_ok || o.ready_bad) begin errors++; $display("FAIL lw_handshake got=%b%b exp=10", o.post_ok, o.ready_bad); end
    endtask

    task automatic test_lb_lbu;
        obs_t o;
        run_op(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h8011_2233, 0, 0, 1'b0, o);
        checks++; if (o.rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got=%h exp=ffffff80", o.rdata); end
        checks++; if (o.addr !== 32'h8000_0000) begin errors++; $display("FAIL lb_addr got=%h exp=80000000", o.addr); end
        run_op(1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h8011_2233, 1, 1, 1'b0, o);
        checks++; if (o.rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_rdata got=%h exp=00000080", o.rdata); end
        checks++; if (o.lat != 5) begin errors++; $display("FAIL lbu_latency got=%0d exp=5", o.lat); end
    endtask

    task automatic test_sh;
        obs_t o;
        run_op(1'b1, 3'b001, 32'h1000_0002, 32'h1234_ABCD, 32'h5555_5555, 0, 0, 1'b0, o);
        checks++; if (o.wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb got=%b exp=1100", o.wstrb); end
        checks++; if (o.wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata got=%h exp=abcdabcd", o.wdata); end
        checks++; if (o.wen !== 1'b1) begin errors++; $display("FAIL sh_wen got=%b exp=1", o.wen); end
        checks++; if (o.rdata !== 32'b0 || o.err !== 1'b0) begin errors++; $display("FAIL sh_resp got=%h/%b exp=0/0", o.rdata, o.err); end
        checks++; if (o.idle_dirty) begin errors++; $display("FAIL sh_idle_outputs got=1 exp=0"); end
    endtask

    task automatic test_misaligned;
        obs_t o;
        run_op(1'b0, 3'b010, 32'h1000_0002, 32'h0, 32'h1111_1111, 0, 0, 1'b0, o);
        checks++; if (o.saw_req) begin errors++; $display("FAIL mis_memreq got=1 exp=0"); end
        checks++; if (!o.got_resp || o.lat != 1) begin errors++; $display("FAIL mis_latency got=%0d exp=1", o.lat); end
        checks++; if (o.err !== 1'b1 || o.rdata !== 32'b0) begin errors++; $display("FAIL mis_resp got=%b/%h exp=1/0", o.err, o.rdata); end
        run_op(1'b1, 3'b100, 32'h1000_0000, 32'hFFFF_FFFF, 32'h0, 0, 0, 1'b0, o);
        checks++; if (o.saw_req || o.err !== 1'b1 || o.lat != 1)
            begin errors++; $display("FAIL illegal_store got=%b/%b/%0d exp=0/1/1", o.saw_req, o.err, o.lat); end
    endtask

    task automatic test_stall;
        obs_t o;
        run_op(1'b1, 3'b010, 32'h2000_0008, 32'hCAFE_F00D, 32'h0, 5, 2, 1'b1, o);
        checks++; if (o.unstable) begin errors++; $display("FAIL stall_stable got=unstable exp=stable"); end
        checks++; if (o.wstrb !== 4'b1111 || o.wdata !== 32'hCAFE_F00D || o.addr !== 32'h2000_0008)
            begin errors++; $display("FAIL stall_fields got=%b/%h/%h exp=1111/cafef00d/20000008", o.wstrb, o.wdata, o.addr); end
        checks++; if (o.lat != 10 || o.ready_bad) begin errors++; $display("FAIL stall_latency got=%0d/%b exp=10/0", o.lat, o.ready_bad); end
    endtask

    task automatic test_stray_idle;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rsp_valid = 1'b1; mem_rdata = $urandom;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
                begin errors++; $display("FAIL stray_idle got=%b%b exp=01", resp_valid, req_ready); end
        end
    endtask

    task automatic test_reset_midop(input bit in_wait);
        bit seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h3000_0000;
        @(negedge clk);
        req_valid = 1'b0;
        mem_req_ready = in_wait;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || resp_valid !== 1'b0)
            begin errors++; $display("FAIL rst_midop_%0d got=%b%b%b exp=100", in_wait, req_ready, mem_req_valid, resp_valid); end
        @(negedge clk);
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rdata = 32'h7777_7777;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        repeat (4) begin
            if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen) begin errors++; $display("FAIL rst_abandon_%0d got=activity exp=none", in_wait); end
    endtask

    task automatic test_random;
        obs_t o;
        logic st;
        logic [2:0] f3;
        logic [31:0] a, wd, rd;
        int rdly, sdly;
        bit e;
        for (int n = 0; n < 60; n++) begin
            st = 1'($urandom_range(1)); f3 = 3'($urandom_range(7)); a = $urandom; wd = $urandom; rd = $urandom;
            rdly = $urandom_range(3); sdly = $urandom_range(3);
            run_op(st, f3, a, wd, rd, rdly, sdly, 1'($urandom_range(1)), o);
            e = exp_err(st, f3, a);
            checks++; if (!o.got_resp || o.lat != (e ? 1 : 3 + rdly + sdly))
                begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", n, o.lat, e ? 1 : 3 + rdly + sdly); end
            checks++; if (o.err !== e) begin errors++; $display("FAIL rnd%0d_err got=%b exp=%b", n, o.err, e); end
            checks++; if (o.rdata !== ((e || st) ? 32'b0 : exp_load(f3, a, rd)))
                begin errors++; $display("FAIL rnd%0d_rdata got=%h exp=%h", n, o.rdata, (e || st) ? 32'b0 : exp_load(f3, a, rd)); end
            checks++; if (o.saw_req !== !e) begin errors++; $display("FAIL rnd%0d_memreq got=%b exp=%b", n, o.saw_req, !e); end
            if (!e) begin
                checks++; if (o.addr !== {a[31:2], 2'b00} || o.wen !== st)
                    begin errors++; $display("FAIL rnd%0d_addr got=%h/%b exp=%h/%b", n, o.addr, o.wen, {a[31:2], 2'b00}, st); end
                checks++; if (o.wstrb !== (st ? exp_strb(f3, a) : 4'b0) || o.wdata !== (st ? exp_wdata(f3, wd) : 32'b0))
                    begin errors++; $display("FAIL rnd%0d_wlane got=%b/%h exp=%b/%h", n, o.wstrb, o.wdata,
                                             st ? exp_strb(f3, a) : 4'b0, st ? exp_wdata(f3, wd) : 32'b0); end
            end
            checks++; if (o.unstable || o.idle_dirty || o.ready_bad || !o.post_ok)
                begin errors++; $display("FAIL rnd%0d_protocol got=%b%b%b%b exp=0001", n, o.unstable, o.idle_dirty, o.ready_bad, o.post_ok); end
        end
    endtask

    initial begin
        test_reset;
        test_lw;
        test_lb_lbu;
        test_sh;
        test_misaligned;
        test_stall;
        test_stray_idle;
        test_reset_midop(1'b0);
        test_reset_midop(1'b1);
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
